// File: rtl/alu_res_buffer_if.sv
// rtl/alu_res_buffer_if.sv - upstream/downstream handshake bundle for alu_res_buffer
interface alu_res_buffer_if #(
  parameter int ancho = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [ancho-1:0] aluresult;
  logic             aluflagin;
  logic             out_valid;
  logic             out_ready;
  logic [ancho-1:0] out_result;
  logic             out_src;
  logic             out_z;
  logic             out_n;
  logic             out_u;

  modport master (
    output in_valid, aluresult, aluflagin, out_ready,
    input  in_ready, out_valid, out_result, out_src, out_z, out_n, out_u
  );

  modport slave (
    input  in_valid, aluresult, aluflagin, out_ready,
    output in_ready, out_valid, out_result, out_src, out_z, out_n, out_u
  );
endinterface

// File: rtl/alu_res_buffer.sv
// rtl/alu_res_buffer.sv - two-entry result FIFO capturing z/n/u flags at push
// Optional sticky zero indicator enabled by defining ALU_RES_STICKY_EN.
module alu_res_buffer #(
  parameter int ancho = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_res_buffer_if.slave  bus,
  output logic [1:0]       count,
  input  logic             sticky_clr,
  output logic             sticky_z
);

  typedef struct packed {
    logic [ancho-1:0] result;
    logic             src;
    logic             z;
    logic             n;
    logic             u;
  } entry_t;

  entry_t mem [2];
  entry_t in_entry;
  entry_t head;
  logic   wptr;
  logic   rptr;
  logic   alive;
  logic   push;
  logic   pop;

  always_comb begin
    in_entry        = '0;
    in_entry.result = bus.aluresult;
    in_entry.src    = bus.aluflagin;
    in_entry.z      = (bus.aluresult == '0);
    in_entry.n      = bus.aluresult[ancho-1];
    in_entry.u      = &bus.aluresult;
  end

  // alive keeps in_ready low through reset and raises it on the first edge after release
  assign bus.in_ready  = alive && (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (push) begin
        mem[wptr] <= in_entry;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // stale slots stay hidden: outputs are zero whenever the FIFO is empty
  assign head = bus.out_valid ? mem[rptr] : '0;

  assign bus.out_result = head.result;
  assign bus.out_src    = head.src;
  assign bus.out_z      = head.z;
  assign bus.out_n      = head.n;
  assign bus.out_u      = head.u;

`ifdef ALU_RES_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_z <= 1'b0;
    end else if (push && in_entry.z) begin
      sticky_z <= 1'b1;
    end else if (sticky_clr) begin
      sticky_z <= 1'b0;
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_z          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_res_buffer.sv
// tb/tb_alu_res_buffer.sv - randomized bench with queue reference model for alu_res_buffer
`timescale 1ns/1ps
module tb_alu_res_buffer;
  localparam int ancho = 4;
`ifdef ALU_RES_STICKY_EN
  localparam bit stk_en = 1'b1;
`else
  localparam bit stk_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sticky_clr = 1'b0;
  logic       sticky_z;
  logic [1:0] count;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;

  logic [ancho:0] mq[$];
  bit             m_alive = 1'b0;
  bit             m_sticky = 1'b0;

  alu_res_buffer_if #(.ancho(ancho)) bif();

  alu_res_buffer #(.ancho(ancho)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bif),
    .count      (count),
    .sticky_clr (sticky_clr),
    .sticky_z   (sticky_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered list of {src,result}; flags are derived from the value on demand
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_alive  = 1'b0;
      m_sticky = 1'b0;
    end else begin
      bit do_push, do_pop;
      do_push = bif.in_valid && m_alive && (mq.size() < 2);
      do_pop  = bif.out_ready && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({bif.aluflagin, bif.aluresult});
      if (stk_en) begin
        if (do_push && bif.aluresult == 0) m_sticky = 1'b1;
        else if (sticky_clr) m_sticky = 1'b0;
      end
      m_alive = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int r;
      bit s, has;
      has = (mq.size() > 0);
      r   = has ? int'(mq[0][ancho-1:0]) : 0;
      s   = has ? mq[0][ancho] : 1'b0;
      chk("count", 32'(count), 32'(mq.size()));
      chk("in_ready", 32'(bif.in_ready), 32'(m_alive && mq.size() < 2));
      chk("out_valid", 32'(bif.out_valid), 32'(has));
      chk("out_result", 32'(bif.out_result), 32'(r));
      chk("out_src", 32'(bif.out_src), 32'(s));
      chk("out_z", 32'(bif.out_z), 32'(has && r == 0));
      chk("out_n", 32'(bif.out_n), 32'(has && r >= 2 ** (ancho - 1)));
      chk("out_u", 32'(bif.out_u), 32'(has && r == 2 ** ancho - 1));
      chk("sticky_z", 32'(sticky_z), 32'(m_sticky));
    end
  end

  task automatic drive(input bit v, input logic [ancho-1:0] r, input bit s, input bit ordy, input bit clr);
    @(negedge clk);
    bif.in_valid  = v;
    bif.aluresult = r;
    bif.aluflagin = s;
    bif.out_ready = ordy;
    sticky_clr    = clr;
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.in_valid  = 1'b0;
    bif.aluresult = '0;
    bif.aluflagin = 1'b0;
    bif.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst in_ready", 32'(bif.in_ready), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst out_result", 32'(bif.out_result), 32'd0);
    chk("rst sticky_z", 32'(sticky_z), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    chk("ready after release", 32'(bif.in_ready), 32'd1);

    // push zero into empty FIFO
    drive(1, 4'h0, 0, 0, 0);
    settle();
    chk("z push valid", 32'(bif.out_valid), 32'd1);
    chk("z push z", 32'(bif.out_z), 32'd1);
    chk("z push n", 32'(bif.out_n), 32'd0);
    chk("z push u", 32'(bif.out_u), 32'd0);
    chk("z push count", 32'(count), 32'd1);
    drive(0, 4'h0, 0, 1, 0);
    settle();
    chk("drain count", 32'(count), 32'd0);

    // fill to two, third push refused
    drive(1, 4'hF, 1, 0, 0);
    drive(1, 4'h7, 0, 0, 0);
    settle();
    chk("full count", 32'(count), 32'd2);
    chk("full in_ready", 32'(bif.in_ready), 32'd0);
    chk("full head", 32'(bif.out_result), 32'hF);
    chk("full head n", 32'(bif.out_n), 32'd1);
    chk("full head u", 32'(bif.out_u), 32'd1);
    chk("full head src", 32'(bif.out_src), 32'd1);
    drive(1, 4'hA, 0, 0, 0);
    settle();
    chk("third refused", 32'(count), 32'd2);

    // drain in order
    drive(0, 4'h0, 0, 1, 0);
    settle();
    chk("second head", 32'(bif.out_result), 32'h7);
    chk("pop count", 32'(count), 32'd1);
    chk("ready back", 32'(bif.in_ready), 32'd1);
    settle();
    chk("empty count", 32'(count), 32'd0);
    chk("empty valid", 32'(bif.out_valid), 32'd0);

    // simultaneous push/pop at count 1
    drive(1, 4'h3, 0, 0, 0);
    settle();
    chk("head 3", 32'(bif.out_result), 32'h3);
    drive(1, 4'h2, 1, 1, 0);
    settle();
    chk("pp count", 32'(count), 32'd1);
    chk("pp head", 32'(bif.out_result), 32'h2);
    for (int i = 0; i < 50; i++) drive(1, 4'(i), 1'(i), 1, 0);
    settle();
    chk("b2b count", 32'(count), 32'd1);
    chk("b2b last", 32'(bif.out_result), 32'h1);
    drive(0, 4'h0, 0, 1, 0);
    settle();

    // sticky zero
    drive(0, 4'h0, 0, 0, 1);
    settle();
    chk("sticky clr", 32'(sticky_z), 32'd0);
    drive(1, 4'h0, 0, 0, 0);
    settle();
    chk("sticky set", 32'(sticky_z), 32'(stk_en));
    drive(1, 4'h5, 0, 0, 0);
    settle();
    chk("sticky hold", 32'(sticky_z), 32'(stk_en));
    drive(0, 4'h0, 0, 1, 1);
    settle();
    chk("sticky cleared", 32'(sticky_z), 32'd0);
    drive(1, 4'h0, 0, 0, 1);
    settle();
    chk("sticky set wins", 32'(sticky_z), 32'(stk_en));
    drive(0, 4'h0, 0, 1, 1);
    settle();
    settle();
    chk("sticky drained", 32'(count), 32'd0);

    // asynchronous reset while full
    drive(1, 4'hF, 0, 0, 0);
    drive(1, 4'h7, 0, 0, 0);
    settle();
    chk("pre-reset count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async count", 32'(count), 32'd0);
    chk("async valid", 32'(bif.out_valid), 32'd0);
    chk("async result", 32'(bif.out_result), 32'd0);
    chk("async in_ready", 32'(bif.in_ready), 32'd0);
    chk("async flags", 32'({bif.out_src, bif.out_z, bif.out_n, bif.out_u}), 32'd0);
    @(negedge clk);
    bif.in_valid = 1'b0;
    rst_n = 1'b1;
    settle();
    chk("post-reset ready", 32'(bif.in_ready), 32'd1);
    chk("post-reset count", 32'(count), 32'd0);

    // random traffic, two out_ready biases
    repeat (600) drive($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    repeat (600) drive($urandom_range(0, 2) == 0, 4'($urandom_range(0, 2) * 7), 1'($urandom),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    drive(0, 4'h0, 0, 1, 0);
    settle();
    settle();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_res_buffer.md
ALU_RES_BUFFER -- requirements
Module: alu_res_buffer

Interface
REQ-001 Parameter: ancho, default 4, result width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream decrement stage presents a result this cycle.
REQ-005 in_ready  output  1  buffer can accept a result this cycle.
REQ-006 aluresult  input  ancho  decremented value from upstream stage.
REQ-007 aluflagin  input  1  operand select used upstream (0 = a-1, 1 = b-1).
REQ-008 out_valid  output  1  head entry is available.
REQ-009 out_ready  input  1  downstream consumes head entry this cycle.
REQ-010 out_result  output  ancho  head entry result.
REQ-011 out_src  output  1  head entry operand select.
REQ-012 out_z  output  1  head entry zero flag.
REQ-013 out_n  output  1  head entry negative flag.
REQ-014 out_u  output  1  head entry underflow flag.
REQ-015 count  output  2  current occupancy, 0..2.
REQ-016 sticky_clr  input  1  synchronous clear of sticky_z.
REQ-017 sticky_z  output  1  sticky zero indicator (see Configuration).

Function
REQ-018 Block SHALL be a 2-entry FIFO; each entry stores {result, src, z, n, u}.
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 Flags SHALL be computed at push: z = (aluresult == 0), n = aluresult[ancho-1], u = (aluresult == all ones), meaning the decrement wrapped from 0.
REQ-021 in_ready SHALL equal (count != 2), derived from registered state only, with no combinational path from out_ready.
REQ-022 out_valid SHALL equal (count != 0); out_* fields SHALL be driven from the head entry register with no combinational path from aluresult.
REQ-023 Latency: a result pushed in cycle N SHALL appear on the outputs in cycle N+1 if the FIFO was empty.
REQ-024 Simultaneous push and pop at count 1: count stays 1 and the pushed entry becomes head in the next cycle.
REQ-025 At count 2 with out_ready = 1: pop only; count becomes 1; in_ready rises the next cycle.
REQ-026 At count 0, out_ready SHALL be ignored; count never underflows or exceeds 2.
REQ-027 Read and write pointers are 1 bit each and SHALL wrap 1 -> 0.
REQ-028 Non-head entry contents SHALL NOT be observable on outputs.
REQ-029 Entries SHALL preserve arrival order with no loss or duplication.

Reset
REQ-030 While rst_n = 0: count = 0, pointers = 0, out_valid = 0, in_ready = 0, out_result = 0, out_src/out_z/out_n/out_u = 0, sticky_z = 0.
REQ-031 in_ready SHALL assert in the first cycle after rst_n deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries immediately, with no pop reported.

Configuration
REQ-033 Macro ALU_RES_STICKY_EN: when defined, sticky_z SHALL set to 1 on any push with z = 1 and hold until sticky_clr = 1 or reset; if sticky_clr and a z = 1 push coincide, sticky_z SHALL be 1.
REQ-034 Without ALU_RES_STICKY_EN: sticky_z SHALL be tied to 0 and sticky_clr ignored; all other behaviour SHALL be identical.

Verification
REQ-035 ancho = 4; push aluresult = 4'h0, src = 0, with out_ready = 0 -> next cycle out_valid = 1, out_z = 1, out_n = 0, out_u = 0, count = 1.
REQ-036 Push 4'hF, then 4'h7, with out_ready = 0 -> count = 2, in_ready = 0; head out_result = F, out_n = 1, out_u = 1; a third in_valid is not accepted.
REQ-037 From count = 2, out_ready = 1 for 2 cycles -> out_result reads F then 7, count reaches 0, out_valid = 0.
REQ-038 At count 1 (head 4'h3), push 4'h2 with out_ready = 1 -> count stays 1 and next head = 2; 50 back-to-back transfers with order preserved.
REQ-039 rst_n pulled low asynchronously at count = 2 -> outputs zero at once, count = 0; in_ready = 1 one cycle after release.
REQ-040 With ALU_RES_STICKY_EN defined, push 4'h0 -> sticky_z = 1; push 4'h5 -> remains 1; sticky_clr -> 0. Without the macro, sticky_z = 0 throughout.
